multi_channel_step_down_counter: RTL and testbench

- Bank of CHANNELS independent registered down-counters. Each counter decrements by a power-of-two step, 2**STEP_LOG2.
- Bits below STEP_LOG2 pass through a decrement unchanged. Only the upper field [WIDTH-1:STEP_LOG2] counts.
- Used for credit/timeout tracking and aligned address walk-down in datapath control, with per-channel load, decrement, zero flag and underflow pulse.
- Wrap vs saturate is chosen per instance.

---
 rtl/multi_channel_step_down_counter_pkg.sv | 28 ++
 rtl/multi_channel_step_down_counter_pow2_step_dec.sv | 27 ++
 rtl/multi_channel_step_down_counter.sv | 112 +++++++++++
 tb/tb_multi_channel_step_down_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_step_down_counter_pkg.sv
// Shared types and width helpers for the step-down counter bank.
// The per-channel count typedef defaults to 8 bits; instances re-derive it from WIDTH.
package multi_channel_step_down_counter_pkg;

  localparam int DEF_WIDTH = 8;

  typedef logic [DEF_WIDTH-1:0] count_t;

  typedef enum logic [1:0] {
    NS_LOAD,
    NS_DEC,
    NS_UNDERFLOW,
    NS_HOLD
  } ns_sel_e;

  function automatic int field_w(input int width, input int step_log2);
    return width - step_log2;
  endfunction

  function automatic int step_val(input int step_log2);
    return 1 << step_log2;
  endfunction

  function automatic bit step_log2_ok(input int width, input int step_log2);
    return (step_log2 >= 0) && (step_log2 < width);
  endfunction

endpackage

// File: rtl/multi_channel_step_down_counter_pow2_step_dec.sv
// Power-of-two step decrement: upper field minus one, low bits passed.
// field_zero flags an all-zero upper field (decrement would wrap).
module pow2_step_dec
  import multi_channel_step_down_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_LOG2 = 0
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             field_zero
);

  localparam int FW = field_w(WIDTH, STEP_LOG2);

  logic [FW-1:0] up;

  assign up         = d[WIDTH-1:STEP_LOG2];
  assign field_zero = (up == '0);

  if (STEP_LOG2 == 0) begin : g_nolow
    assign q = up - FW'(1);
  end else begin : g_low
    assign q = {up - FW'(1), d[STEP_LOG2-1:0]};
  end

endmodule

// File: rtl/multi_channel_step_down_counter.sv
// Bank of independent power-of-two step down-counters with zero/underflow.
// Define STEP_DOWN_COUNTER_AUTO_RELOAD_EN to reload from a shadow on underflow.
module multi_channel_step_down_counter
  import multi_channel_step_down_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_LOG2 = 0,
  parameter int CHANNELS  = 1,
  parameter int SATURATE  = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [CHANNELS-1:0]              load_i,
  input  logic [CHANNELS-1:0][WIDTH-1:0]   load_data_i,
  input  logic [CHANNELS-1:0]              dec_i,
  output logic [CHANNELS-1:0][WIDTH-1:0]   count_o,
  output logic [CHANNELS-1:0]              zero_o,
  output logic [CHANNELS-1:0]              underflow_o
);

  typedef logic [WIDTH-1:0] cnt_t;

  if (!step_log2_ok(WIDTH, STEP_LOG2)) begin : g_bad_step
    $error("STEP_LOG2 must lie in 0..WIDTH-1");
  end
  if (CHANNELS < 1) begin : g_bad_ch
    $error("CHANNELS must be at least 1");
  end
  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
    $error("SATURATE must be 0 or 1");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    cnt_t    cnt_q;
    cnt_t    cnt_d;
    cnt_t    dec_v;
    logic    fz;
    logic    zero_q;
    logic    zero_d;
    logic    uf_q;
    logic    uf_d;
    ns_sel_e sel;

    pow2_step_dec #(
      .WIDTH     (WIDTH),
      .STEP_LOG2 (STEP_LOG2)
    ) u_dec (
      .d          (cnt_q),
      .q          (dec_v),
      .field_zero (fz)
    );

`ifdef STEP_DOWN_COUNTER_AUTO_RELOAD_EN
    cnt_t shadow_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        shadow_q <= '0;
      end else if (load_i[c]) begin
        shadow_q <= load_data_i[c];
      end
    end
`endif

    always_comb begin
      sel = NS_HOLD;
      unique case (1'b1)
        load_i[c]:                     sel = NS_LOAD;
        !load_i[c] && dec_i[c] && !fz: sel = NS_DEC;
        !load_i[c] && dec_i[c] && fz:  sel = NS_UNDERFLOW;
        default:                       sel = NS_HOLD;
      endcase
    end

    always_comb begin
      cnt_d = cnt_q;
      uf_d  = 1'b0;
      case (sel)
        NS_LOAD: cnt_d = load_data_i[c];
        NS_DEC:  cnt_d = dec_v;
        NS_UNDERFLOW: begin
          uf_d = 1'b1;
`ifdef STEP_DOWN_COUNTER_AUTO_RELOAD_EN
          cnt_d = shadow_q;
`else
          // wrapping is the same field-minus-one the decrementer produces
          cnt_d = (SATURATE != 0) ? cnt_q : dec_v;
`endif
        end
        default: cnt_d = cnt_q;
      endcase
      zero_d = ((cnt_d >> STEP_LOG2) == '0);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q  <= '0;
        zero_q <= 1'b1;
        uf_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        zero_q <= zero_d;
        uf_q   <= uf_d;
      end
    end

    assign count_o[c]     = cnt_q;
    assign zero_o[c]      = zero_q;
    assign underflow_o[c] = uf_q;
  end

endmodule

// File: tb/tb_multi_channel_step_down_counter.sv
// Bench for the step-down counter bank: wrap and saturate instances side by side,
// directed plan steps then random traffic against an arithmetic reference model.
module tb_multi_channel_step_down_counter;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int C    = 2;
  localparam int STEP = 1 << S;
  localparam int NF   = (1 << W) / STEP;

  logic clk = 1'b0;
  logic rst;
  logic [C-1:0]        load;
  logic [C-1:0]        dec;
  logic [C-1:0][W-1:0] ld;
  logic [C-1:0][W-1:0] cnt0, cnt1;
  logic [C-1:0]        z0, z1, u0, u1;

  int total  = 0;
  int passed = 0;

  int m_cnt [2][C];
  int m_sh  [2][C];
  bit m_uf  [2][C];

  always #5 clk = ~clk;

  multi_channel_step_down_counter #(
    .WIDTH(W), .STEP_LOG2(S), .CHANNELS(C), .SATURATE(0)
  ) dut_wrap (
    .clk_i(clk), .rst_i(rst), .load_i(load), .load_data_i(ld),
    .dec_i(dec), .count_o(cnt0), .zero_o(z0), .underflow_o(u0)
  );

  multi_channel_step_down_counter #(
    .WIDTH(W), .STEP_LOG2(S), .CHANNELS(C), .SATURATE(1)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst), .load_i(load), .load_data_i(ld),
    .dec_i(dec), .count_o(cnt1), .zero_o(z1), .underflow_o(u1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: count/STEP is the field, count%STEP the untouched low bits.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < C; c++) begin
        if (rst) begin
          m_cnt[d][c] = 0;
          m_sh[d][c]  = 0;
          m_uf[d][c]  = 0;
        end else if (load[c]) begin
          m_cnt[d][c] = int'(ld[c]);
          m_sh[d][c]  = int'(ld[c]);
          m_uf[d][c]  = 0;
        end else if (dec[c]) begin
          if (m_cnt[d][c] / STEP != 0) begin
            m_cnt[d][c] = m_cnt[d][c] - STEP;
            m_uf[d][c]  = 0;
          end else begin
            m_uf[d][c] = 1;
`ifdef STEP_DOWN_COUNTER_AUTO_RELOAD_EN
            m_cnt[d][c] = m_sh[d][c];
`else
            if (d == 0)
              m_cnt[d][c] = (NF - 1) * STEP + m_cnt[d][c] % STEP;
`endif
          end
        end else begin
          m_uf[d][c] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < C; c++) begin
      chk($sformatf("%s.wrap.cnt%0d", tag, c), 32'(cnt0[c]), 32'(m_cnt[0][c]));
      chk($sformatf("%s.wrap.zero%0d", tag, c), 32'(z0[c]),
          32'(m_cnt[0][c] / STEP == 0));
      chk($sformatf("%s.wrap.uf%0d", tag, c), 32'(u0[c]), 32'(m_uf[0][c]));
      chk($sformatf("%s.sat.cnt%0d", tag, c), 32'(cnt1[c]), 32'(m_cnt[1][c]));
      chk($sformatf("%s.sat.zero%0d", tag, c), 32'(z1[c]),
          32'(m_cnt[1][c] / STEP == 0));
      chk($sformatf("%s.sat.uf%0d", tag, c), 32'(u1[c]), 32'(m_uf[1][c]));
    end
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst  = 1'b1;
    load = '0;
    dec  = '0;
    ld   = '0;

    cyc("reset");
    cyc("reset");
    chk("reset.cnt_const", 32'(cnt0), 32'h0);
    chk("reset.zero_const", 32'(z0), 32'h3);

    rst     = 1'b0;
    load[0] = 1'b1;
    ld[0]   = 8'h0B;
    cyc("p2.load");
    load = '0;
    dec  = 2'b01;
    repeat (4) cyc("p2.dec");
`ifndef STEP_DOWN_COUNTER_AUTO_RELOAD_EN
    chk("p2.wrap_final", 32'(cnt0[0]), 32'hFB);
    chk("p2.sat_final", 32'(cnt1[0]), 32'h03);
`endif
    chk("p2.ch1_idle", 32'(cnt0[1]), 32'h00);

    dec     = '0;
    load[1] = 1'b1;
    ld[1]   = 8'h05;
    cyc("p3.load");
    load = '0;
    dec  = 2'b10;
    repeat (3) cyc("p3.dec");
`ifndef STEP_DOWN_COUNTER_AUTO_RELOAD_EN
    chk("p3.sat_hold", 32'(cnt1[1]), 32'h01);
    chk("p3.sat_uf", 32'(u1[1]), 32'h1);
`endif

    load  = 2'b01;
    dec   = 2'b01;
    ld[0] = 8'h20;
    cyc("p4.load_dec");
    chk("p4.load_wins", 32'(cnt0[0]), 32'h20);
    load = '0;
    dec  = 2'b11;
    repeat (2) cyc("p4.both");

    load  = 2'b01;
    dec   = 2'b00;
    ld[0] = 8'h40;
    cyc("p5.load");
    load = '0;
    dec  = 2'b01;
    repeat (3) cyc("p5.dec");
    rst = 1'b1;
    cyc("p5.rst");
    chk("p5.rst_cnt", 32'(cnt0[0]), 32'h00);
    chk("p5.rst_uf", 32'(u0[0]), 32'h0);
    rst = 1'b0;
    cyc("p5.after");

    dec   = '0;
    load  = 2'b01;
    ld[0] = 8'h08;
    cyc("p6.load");
    load = '0;
    dec  = 2'b01;
    repeat (3) cyc("p6.dec");
`ifdef STEP_DOWN_COUNTER_AUTO_RELOAD_EN
    chk("p6.reload_wrap", 32'(cnt0[0]), 32'h08);
    chk("p6.reload_sat", 32'(cnt1[0]), 32'h08);
    chk("p6.reload_uf", 32'(u0[0]), 32'h1);
`endif

    repeat (400) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < C; c++) begin
        load[c] = ($urandom_range(0, 5) == 0);
        dec[c]  = ($urandom_range(0, 3) != 0);
        ld[c]   = W'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0)
          ld[c] = W'($urandom_range(0, 7));
      end
      cyc("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
